// File: rtl/axi_s3_mem_responder.sv
// AXI3 slave-3 memory: one write and one read burst in flight, read data one cycle after AR.
// Every channel is valid/ready; R and B outputs hold while the master stalls.
module axi_s3_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_6000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [5:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [5:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [5:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int IW = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic in_window(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
           ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 33'd4095));
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // WRAP keeps the bits above the (len+1)-word block and increments only inside it
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                             input logic [1:0] burst,
                                             input logic [7:0] len);
    logic [IW-1:0] inc;
    logic [IW-1:0] mask;
    logic [IW-1:0] res;
    inc  = idx + IW'(1);
    mask = IW'(len);
    case (burst)
      2'b00:   res = idx;
      2'b10:   res = (idx & ~mask) | (inc & mask);
      default: res = inc;
    endcase
    return res;
  endfunction

  // ---------------- write channel ----------------
  logic [1:0]    w_state;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len;
  logic [1:0]    w_burst;
  logic          w_dec;
  logic          w_err;
  logic [8:0]    w_cnt;
  logic [8:0]    w_beats;
  logic          w_en;

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign w_beats = w_cnt + 9'd1;
  // beats past awlen+1 are never stored; the burst is already doomed to SLVERR
  assign w_en    = wvalid && wready && !w_dec && !w_err && (w_cnt <= {1'b0, w_len});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_idx   <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_dec   <= 1'b0;
      w_err   <= 1'b0;
      w_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          bid     <= awid;
          w_idx   <= awaddr[IW+1:2];
          w_len   <= awlen;
          w_burst <= awburst;
          w_dec   <= !in_window(awaddr);
          w_err   <= burst_bad(awburst, awlen);
          w_cnt   <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_idx <= next_idx(w_idx, w_burst, w_len);
          if (w_cnt != '1) w_cnt <= w_beats;
          if (wlast) begin
            w_state <= W_RESP;
            if (w_dec)
              bresp <= RESP_DECERR;
            else if (w_err || (w_beats != ({1'b0, w_len} + 9'd1)))
              bresp <= RESP_SLVERR;
            else
              bresp <= RESP_OKAY;
          end
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) mem[w_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic          r_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] ar_idx;
  logic [7:0]    r_len;
  logic [1:0]    r_burst;
  logic [7:0]    r_cnt;
  logic          r_ok;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign ar_idx  = araddr[IW+1:2];

  // nonblocking mem reads see the value before any same-edge write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      rlast   <= 1'b0;
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_ok    <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (arvalid) begin
        rid     <= arid;
        r_len   <= arlen;
        r_burst <= arburst;
        r_cnt   <= '0;
        rlast   <= (arlen == 8'd0);
        r_idx   <= next_idx(ar_idx, arburst, arlen);
        r_state <= R_DATA;
        if (!in_window(araddr)) begin
          rresp <= RESP_DECERR;
          r_ok  <= 1'b0;
          rdata <= '0;
        end else if (burst_bad(arburst, arlen)) begin
          rresp <= RESP_SLVERR;
          r_ok  <= 1'b0;
          rdata <= '0;
        end else begin
          rresp <= RESP_OKAY;
          r_ok  <= 1'b1;
          rdata <= mem[ar_idx];
        end
      end
    end else if (rready) begin
      if (rlast) begin
        r_state <= R_IDLE;
        rlast   <= 1'b0;
      end else begin
        rdata <= r_ok ? mem[r_idx] : '0;
        r_idx <= next_idx(r_idx, r_burst, r_len);
        r_cnt <= r_cnt + 8'd1;
        rlast <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

endmodule

// File: doc/axi_s3_mem_responder.md
AXI_S3_MEM_RESPONDER -- requirements
Module: axi_s3_mem_responder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rstn.
REQ-002 Parameter BASE_ADDR SHALL default to 32'h0000_6000 and set the base of the 4 KB window served as slave 3.
REQ-003 Parameter MEM_WORDS SHALL default to 1024 and set the number of 32-bit storage words.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 awid  in  6  write ID.
REQ-007 awaddr  in  32  write start byte address.
REQ-008 awlen  in  8  write beats minus 1.
REQ-009 awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 awvalid/awready  in/out  1  AW handshake.
REQ-011 wdata  in  32  write data.
REQ-012 wstrb  in  4  byte enables.
REQ-013 wlast  in  1  final write beat.
REQ-014 wvalid/wready  in/out  1  W handshake.
REQ-015 bid  out  6  response ID, equals the captured awid.
REQ-016 bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-017 bvalid/bready  out/in  1  B handshake.
REQ-018 arid  in  6  read ID.
REQ-019 araddr  in  32  read start byte address.
REQ-020 arlen  in  8  read beats minus 1.
REQ-021 arburst  in  2  same encoding as awburst.
REQ-022 arvalid/arready  in/out  1  AR handshake.
REQ-023 rid  out  6  equals the captured arid.
REQ-024 rdata  out  32  read data.
REQ-025 rresp  out  2  same encoding as bresp.
REQ-026 rlast  out  1  final read beat.
REQ-027 rvalid/rready  out/in  1  R handshake.

Function
REQ-028 The write FSM SHALL have three states:
- W_IDLE: awready=1.
- W_DATA: wready=1.
- W_RESP: bvalid=1.
- Transitions: AW handshake -> W_DATA; W handshake with wlast=1 -> W_RESP; B handshake -> W_IDLE.
REQ-029 The read FSM SHALL be independent of the write FSM and SHALL have two states:
- R_IDLE: arready=1.
- R_DATA: rvalid=1.
- Transitions: AR handshake -> R_DATA; R handshake with rlast=1 -> R_IDLE.
REQ-030 Each direction SHALL allow at most one outstanding burst, with no ID reordering.
REQ-031 Address decode SHALL be in range when BASE_ADDR <= addr <= BASE_ADDR+4095.
- Out-of-range write: write beats are accepted and discarded; bresp=DECERR.
- Out-of-range read: every beat returns rdata=0 with rresp=DECERR.
REQ-032 Reserved burst type 11 SHALL give SLVERR with no memory update and rdata=0, unless DECERR applies, which has priority.
REQ-033 Word index SHALL be addr[11:2], and addresses SHALL be treated as 4-byte aligned.
- INCR: +1 word per beat, wrapping modulo MEM_WORDS.
- FIXED: the index holds for every beat.
- WRAP: the index wraps within an aligned block of (len+1) words; a len other than 1, 3, 7 or 15 gives SLVERR.
REQ-034 On each W handshake, memory byte k SHALL be written only when wstrb[k]=1 and the burst is OKAY-eligible.
REQ-035 If the wlast beat count differs from awlen+1, bresp SHALL be SLVERR (DECERR takes priority), and the wlast=1 beat SHALL still end the burst.
REQ-036 Read timing:
- AR handshake at edge N: rvalid=1 and rdata=mem[index] from edge N+1.
- Each R handshake loads the next beat on the same edge.
- rlast=1 exactly on beat arlen+1.
- rdata, rresp and rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-037 Write and read of the same word on the same edge SHALL return pre-write data.
REQ-038 bvalid SHALL assert the cycle after the wlast handshake and hold until bready.

Reset
REQ-039 With rstn=0, the block SHALL set:
- Both FSMs to idle, so awready=1 and arready=1.
- wready=0, bvalid=0, rvalid=0, rlast=0.
- bid, rid, bresp, rresp and rdata to 0.
- Memory contents are not reset.
REQ-040 Reset asserted mid-burst SHALL abandon the burst immediately, and no pending response SHALL be issued after release.

Verification
REQ-041 The bench SHALL cover the following directed scenarios:
- INCR write: awaddr=0x6000, awlen=3, data 1..4, wstrb=F -> bresp=OKAY, bid echoed; a following read of len 3 returns 1,2,3,4 with rlast on beat 4.
- Out of range: write to 0x7000 -> bresp=DECERR and memory unchanged; read at 0x5FFC -> rresp=DECERR and rdata=0.
- Byte strobes: word 0x6010 preloaded 0xAABBCCDD, write 0x11223344 with wstrb=0101 -> readback 0xAA22CC44.
- WRAP: read at 0x6008 with arlen=3 -> beats come from 0x6008, 0x600C, 0x6000, 0x6004.
- Backpressure and wlast mismatch: rready low for 3 cycles holds R stable; awlen=2 with wlast on beat 2 -> SLVERR.
- Reset mid-burst: rstn pulsed during W_DATA -> wready=0 and bvalid=0 until the next AW.
